// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter, LSB first; optional even-parity bit when SERIAL_TX_PARITY_EN is defined.
// Latency: line goes low on the accept edge; each bit lasts delay cycles; a frame is 10*delay (11*delay with parity) cycles.
// Backpressure: ready is high only in IDLE; dataValid while busy is dropped, not queued.
module serial_tx #(
    parameter int counterBits = 2,
    parameter int delay       = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] data,
    input  logic       dataValid,
    output logic       ready,
    output logic       serialOut
);

    localparam logic [counterBits-1:0] RELOAD = counterBits'(delay - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t                 state, state_nxt;
    logic [7:0]             shift, shift_nxt;
    logic [counterBits-1:0] cnt, cnt_nxt;
    logic [2:0]             idx, idx_nxt;
    logic                   line_nxt;
    logic                   ready_nxt;
    logic                   bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic                   par, par_nxt;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            shift     <= '0;
            cnt       <= '0;
            idx       <= '0;
            serialOut <= 1'b1;
            ready     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            serialOut <= line_nxt;
            ready     <= ready_nxt;
`ifdef SERIAL_TX_PARITY_EN
            par       <= par_nxt;
`endif
        end
    end

    assign bit_end = (cnt == '0);

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
`ifdef SERIAL_TX_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: begin
                if (dataValid) begin
                    shift_nxt = data;
                    cnt_nxt   = RELOAD;
                    idx_nxt   = '0;
                    state_nxt = START;
`ifdef SERIAL_TX_PARITY_EN
                    par_nxt   = ^data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_nxt   = RELOAD;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt   = RELOAD;
                    shift_nxt = shift >> 1;
                    if (idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = RELOAD;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the line changes on the same edge as the state.
    always_comb begin
        line_nxt  = 1'b1;
        ready_nxt = 1'b0;
        case (state_nxt)
            IDLE:  ready_nxt = 1'b1;
            START: line_nxt  = 1'b0;
            DATA:  line_nxt  = shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: line_nxt = par_nxt;
`endif
            STOP:  line_nxt  = 1'b1;
            default: begin
                line_nxt  = 1'b1;
                ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (delay=3): reset, single byte, busy ignore, back-to-back, mid-frame reset, optional parity.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int DLY = 3;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] data;
    logic       dataValid;
    logic       ready;
    logic       serialOut;

    int n_total = 0;
    int n_pass  = 0;

    serial_tx #(.counterBits(2), .delay(DLY)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .data      (data),
        .dataValid (dataValid),
        .ready     (ready),
        .serialOut (serialOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Covers the edge that accepts b and the whole frame, then the single idle cycle after it.
    task automatic run_frame(input logic [7:0] b, input bit drop_valid, input bit poke);
        logic [10:0] bits;
        logic [7:0]  rx;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef SERIAL_TX_PARITY_EN
        bits[9] = ^b;
`endif
        rx = '0;
        @(posedge clk);
        for (int i = 0; i < NBITS * DLY; i++) begin
            @(negedge clk);
            if (i == 0 && drop_valid) dataValid = 1'b0;
            if (poke && i == 7) begin
                dataValid = 1'b1;
                data = 8'hFF;
            end
            if (poke && i == 8) begin
                dataValid = 1'b0;
                data = 8'h81;
            end
            check($sformatf("frame_%h_c%0d", b, i), {6'd0, ready, serialOut}, {6'd0, 1'b0, bits[i/DLY]});
            if ((i % DLY) == 1 && (i / DLY) >= 1 && (i / DLY) <= 8) rx[(i/DLY)-1] = serialOut;
        end
        check($sformatf("rx_byte_%h", b), rx, b);
        @(negedge clk);
        check($sformatf("idle_after_%h", b), {6'd0, ready, serialOut}, 8'h03);
    endtask

    initial begin
        resetN    = 1'b0;
        dataValid = 1'b1;
        data      = 8'h65;

        // Reset held with a pending request: line idle, nothing starts.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_hold", {6'd0, ready, serialOut}, 8'h03);
        end

        // Release; the next edge accepts 0x65. Busy pokes with 0xFF must not disturb the frame.
        resetN = 1'b1;
        run_frame(8'h65, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_ff", {6'd0, ready, serialOut}, 8'h03);
        end

        // Back-to-back with dataValid held: exactly one idle cycle between frames.
        dataValid = 1'b1;
        data      = 8'hA5;
        run_frame(8'hA5, 1'b0, 1'b0);
        data = 8'h3C;
        run_frame(8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        check("idle_after_b2b", {6'd0, ready, serialOut}, 8'h03);

        // Reset in the middle of data bit 4 (0xEF has bit 4 low).
        dataValid = 1'b1;
        data      = 8'hEF;
        @(posedge clk);
        @(negedge clk);
        dataValid = 1'b0;
        repeat (16) @(negedge clk);
        check("mid_bit4_low", {6'd0, ready, serialOut}, 8'h00);
        #2 resetN = 1'b0;
        #1 check("async_reset", {6'd0, ready, serialOut}, 8'h03);
        @(negedge clk);
        check("reset_held_mid", {6'd0, ready, serialOut}, 8'h03);
        resetN    = 1'b1;
        dataValid = 1'b1;
        data      = 8'h00;
        run_frame(8'h00, 1'b1, 1'b0);

`ifdef SERIAL_TX_PARITY_EN
        dataValid = 1'b1;
        data      = 8'h01;
        run_frame(8'h01, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
UART-style serial transmitter, 8N1 framing, LSB first. It is the transmit-side counterpart of the SerialRx receiver and uses the same bit-timing parameters, so a loopback of serialOut into SerialRx recovers the sent byte. It sits between the core's output latch and the external serial pin. Its only flow control is a valid/ready handshake on the parallel side.

Parameters:
counterBits, 2, width of the bit-period counter; must satisfy 2^counterBits >= delay
delay, 3, clock cycles per serial bit; legal range 2 .. 2^counterBits

Ports:
clk  input  1  system clock; all state changes on rising edge
resetN  input  1  asynchronous, active-low reset
data  input  8  byte to send; sampled only on an accepted handshake
dataValid  input  1  request to send data
ready  output  1  high when idle and able to accept a byte
serialOut  output  1  serial line; idle/mark level is 1

Behaviour:
- Reset (resetN=0, asynchronous, overrides everything): state=IDLE, serialOut=1, ready=1, shift register and counters cleared. The same applies mid-frame: the line returns to 1 immediately and the partial frame is abandoned.
- States and line levels:
  - IDLE: serialOut=1, ready=1.
  - START: serialOut=0.
  - DATA: serialOut=shift[0]; bits 0..7.
  - STOP: serialOut=1.
- Accept rule: on a rising edge with dataValid=1 and ready=1:
  - latch data into the shift register;
  - set the bit counter to delay-1;
  - state=START, ready=0, serialOut=0 from that edge.
- dataValid while ready=0 is ignored and not queued. data changes while busy have no effect.
- Bit timing: every bit (start, each data bit, stop) is held exactly delay cycles. The counter decrements each cycle; on the cycle it reads 0 the bit ends and it reloads delay-1.
- DATA state: a 3-bit index counts 0..7. At each bit end the shift register shifts right by one. After bit 7 ends, state=STOP.
- STOP: after delay cycles, state=IDLE and ready=1.
- Frame length: serialOut is low for the start bit exactly delay cycles after acceptance. The total frame occupies 10*delay cycles.
- Back-to-back: ready is high for at least one cycle between frames. The minimum accept-to-accept spacing is 10*delay+1 cycles.
- dataValid held high continuously: each time IDLE is reached, the current data is taken and a new frame starts.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA bit 7 and STOP. It drives even parity (XOR of the 8 latched data bits) for delay cycles. Frame length becomes 11*delay cycles and minimum spacing 11*delay+1. The parity value is computed from the latched byte, not the live data input.
- Undefined: there is no PARITY state and no parity logic; framing is 8N1 exactly as above.

Test Plan:
- Reset: drive resetN=0 with dataValid=1 -> serialOut=1 and ready=1 throughout; no frame starts. Release reset -> first accept occurs on the next edge.
- Single byte: delay=3, send 8'h65 (0110_0101) -> serialOut reads (3 cycles each) 0, then 1,0,1,0,0,1,1,0 (LSB first), then 1. ready=0 for 30 cycles, then 1.
- Busy ignore / data stability: while busy, pulse dataValid with 8'hFF and change data -> the frame in flight is unchanged and the FF byte is never sent.
- Back-to-back: hold dataValid=1 with 8'hA5 then 8'h3C -> two correct frames with exactly one idle cycle (serialOut=1, ready=1) between them. Loopback into SerialRx (counterBits=2, delay=3) -> its data equals 8'hA5 then 8'h3C, with dataReady after each stop bit.
- Reset mid-frame: assert resetN=0 during data bit 4 -> serialOut=1 and ready=1 immediately, without waiting for a clock. After release, send 8'h00 -> a clean full frame.
- Parity (SERIAL_TX_PARITY_EN defined): 8'h65 gives parity 0 and 8'h01 gives parity 1 -> each parity bit lasts 3 cycles and the frame lasts 33 cycles.
